prewish_mentor_q: RTL and testbench

Parametrised, buffered successor to the prewish mentor. A test-side source writes words by pulsing `STB_I`. The block queues them in a FIFO of 2^`DEPTH_LOG2` entries and replays each one toward the blinky side over a strobe/acknowledge handshake. The block adds back-to-back delivery, overflow reporting and an optional input synchroniser.

---
 rtl/prewish_mentor_q.sv | 119 +++++++++++
 tb/tb_prewish_mentor_q.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prewish_mentor_q.sv
// Buffered strobe/acknowledge mentor: rising STB_I edges enqueue DAT_I, and the
// queue is replayed on STB_O/DAT_O. Define PREWISH_MENTOR_SYNC_EN to add a two-flop input synchroniser.
module prewish_mentor_q #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  STB_I,
    input  logic [DATA_W-1:0]     DAT_I,
    output logic                  STB_O,
    output logic [DATA_W-1:0]     DAT_O,
    input  logic                  ACK_I,
    output logic [DEPTH_LOG2:0]   LEVEL_O,
    output logic                  OVF_O
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic              stb_s;
    logic [DATA_W-1:0] dat_s;

`ifdef PREWISH_MENTOR_SYNC_EN
    logic [1:0]        stb_sync_reg;
    logic [DATA_W-1:0] dat_sync0_reg;
    logic [DATA_W-1:0] dat_sync1_reg;

    // Strobe stages reset high so a strobe held through reset never looks like a rise.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            stb_sync_reg  <= 2'b11;
            dat_sync0_reg <= '0;
            dat_sync1_reg <= '0;
        end else begin
            stb_sync_reg  <= {stb_sync_reg[0], STB_I};
            dat_sync0_reg <= DAT_I;
            dat_sync1_reg <= dat_sync0_reg;
        end
    end

    assign stb_s = stb_sync_reg[1];
    assign dat_s = dat_sync1_reg;
`else
    assign stb_s = STB_I;
    assign dat_s = DAT_I;
`endif

    logic                  stb_hist_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic [0:0]            state_reg;
    logic [0:0]            state_next;
    logic [DATA_W-1:0]     dat_o_reg;
    logic                  ovf_reg;
    logic [DATA_W-1:0]     mem_reg [DEPTH];

    logic rise;
    logic full;
    logic wr_en;
    logic pop;

    assign rise  = stb_s & ~stb_hist_reg;
    assign full  = (level_reg == DEPTH_CNT);
    assign wr_en = rise & ~full;
    // Fetch in IDLE whenever data waits; in PRESENT only once the current word is acknowledged.
    assign pop   = (level_reg != '0) & ((state_reg == ST_IDLE) | ACK_I);

    always_comb begin
        state_next = state_reg;
        if (pop)
            state_next = ST_PRESENT;
        else if ((state_reg == ST_PRESENT) && ACK_I)
            state_next = ST_IDLE;
    end

    always_ff @(posedge CLK_I) begin
        if (wr_en)
            mem_reg[wr_ptr_reg] <= dat_s;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            stb_hist_reg <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            state_reg    <= ST_IDLE;
            dat_o_reg    <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            stb_hist_reg <= stb_s;
            state_reg    <= state_next;
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
                dat_o_reg  <= mem_reg[rd_ptr_reg];
            end
            case ({wr_en, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (rise && full)
                ovf_reg <= 1'b1;
        end
    end

    assign STB_O   = (state_reg == ST_PRESENT);
    assign DAT_O   = dat_o_reg;
    assign LEVEL_O = level_reg;
    assign OVF_O   = ovf_reg;

endmodule

// File: tb/tb_prewish_mentor_q.sv
// Bench for prewish_mentor_q: directed checks on a default instance, then randomized
// traffic on a 16-bit, depth-8 instance compared against a queue reference model.
module tb_prewish_mentor_q;

`ifdef PREWISH_MENTOR_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam int DEPTH_W = 8;
    localparam int N_RAND  = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, ack;
    logic [7:0]  dat;
    logic        stb_o;
    logic [7:0]  dat_o;
    logic [2:0]  level;
    logic        ovf;

    logic        stb_w, ack_w;
    logic [15:0] dat_w;
    logic        stb_o_w;
    logic [15:0] dat_o_w;
    logic [3:0]  level_w;
    logic        ovf_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    prewish_mentor_q u_dut (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb), .DAT_I(dat),
        .STB_O(stb_o), .DAT_O(dat_o), .ACK_I(ack),
        .LEVEL_O(level), .OVF_O(ovf)
    );

    prewish_mentor_q #(.DATA_W(16), .DEPTH_LOG2(3)) u_dut_w (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb_w), .DAT_I(dat_w),
        .STB_O(stb_o_w), .DAT_O(dat_o_w), .ACK_I(ack_w),
        .LEVEL_O(level_w), .OVF_O(ovf_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        dat = d;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        tick();
    endtask

    logic [15:0] model_q[$];
    int          sent, received, budget;
    logic [15:0] exp_word;

    initial begin
        rst_n = 1'b0; stb = 1'b0; ack = 1'b0; dat = '0;
        stb_w = 1'b0; ack_w = 1'b0; dat_w = '0;
        #3;
        check("rst_stb_o", 32'(stb_o), 32'd0);
        check("rst_dat_o", 32'(dat_o), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single write, latency and hold with no acknowledge
        dat = 8'hA5; stb = 1'b1;
        repeat (LAT - 1) tick();
        check("single_early_stb", 32'(stb_o), 32'd0);
        tick();
        check("single_stb", 32'(stb_o), 32'd1);
        check("single_dat", 32'(dat_o), 32'hA5);
        stb = 1'b0;
        repeat (3) tick();
        check("single_hold_stb", 32'(stb_o), 32'd1);
        check("single_hold_dat", 32'(dat_o), 32'hA5);
        ack = 1'b1; tick(); ack = 1'b0;
        check("single_ack_stb", 32'(stb_o), 32'd0);
        check("single_ack_level", 32'(level), 32'd0);
        $display("xfer single data=a5");

        // Burst of five, then back-to-back drain
        for (int i = 1; i <= 5; i++) write_word(8'(i));
        repeat (LAT) tick();
        check("burst_dat", 32'(dat_o), 32'h01);
        check("burst_level", 32'(level), 32'd4);
        check("burst_ovf", 32'(ovf), 32'd0);
        ack = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("burst_drain_dat", 32'(dat_o), 32'(i));
            check("burst_drain_stb", 32'(stb_o), 32'd1);
            $display("xfer burst data=%02h", dat_o);
        end
        tick();
        check("burst_end_stb", 32'(stb_o), 32'd0);
        ack = 1'b0;

        // Overflow: sixth word dropped, flag sticky
        for (int i = 1; i <= 6; i++) write_word(8'(i));
        repeat (LAT) tick();
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_dat", 32'(dat_o), 32'h01);
        ack = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("ovf_drain_dat", 32'(dat_o), 32'(i));
        end
        tick();
        check("ovf_end_stb", 32'(stb_o), 32'd0);
        ack = 1'b0;
        repeat (3) tick();
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Asynchronous reset with words queued
        for (int i = 0; i < 4; i++) write_word(8'(8'h11 + i));
        repeat (LAT) tick();
        check("midrst_pre_level", 32'(level), 32'd3);
        check("midrst_pre_stb", 32'(stb_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_stb", 32'(stb_o), 32'd0);
        check("midrst_dat", 32'(dat_o), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Held strobe gives one write
        dat = 8'h3C; stb = 1'b1;
        repeat (10) tick();
        stb = 1'b0;
        repeat (LAT) tick();
        check("held_stb", 32'(stb_o), 32'd1);
        check("held_dat", 32'(dat_o), 32'h3C);
        check("held_level", 32'(level), 32'd0);
        ack = 1'b1; tick(); ack = 1'b0;
        repeat (LAT) tick();
        check("held_after_stb", 32'(stb_o), 32'd0);
        check("held_after_level", 32'(level), 32'd0);

        // Strobe high across reset release
        stb = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("rstrel_level", 32'(level), 32'd0);
        check("rstrel_stb", 32'(stb_o), 32'd0);
        stb = 1'b0;
        tick();

        // Wide instance: latency from idle
        dat_w = 16'h1234; stb_w = 1'b1;
        repeat (LAT - 1) tick();
        check("w_lat_early", 32'(stb_o_w), 32'd0);
        tick();
        check("w_lat_stb", 32'(stb_o_w), 32'd1);
        check("w_lat_dat", 32'(dat_o_w), 32'h1234);
        stb_w = 1'b0;
        ack_w = 1'b1; tick(); ack_w = 1'b0;
        check("w_lat_done", 32'(stb_o_w), 32'd0);

        // Wide instance: random traffic against a FIFO model
        sent = 0; received = 0; budget = 0;
        while (received < N_RAND && budget < 3000) begin
            ack_w = ($urandom_range(0, 9) < 6);
            if (stb_o_w && ack_w) begin
                if (model_q.size() == 0) begin
                    check("rand_unexpected", 32'(dat_o_w), 32'hFFFFFFFF);
                end else begin
                    exp_word = model_q.pop_front();
                    check("rand_data", 32'(dat_o_w), 32'(exp_word));
                    $display("xfer rand %0d data=%04h", received, dat_o_w);
                end
                received++;
            end
            if (stb_w) begin
                stb_w = 1'b0;
            end else if (sent < N_RAND && (sent - received) < DEPTH_W && $urandom_range(0, 1) == 1) begin
                dat_w = 16'($urandom);
                stb_w = 1'b1;
                model_q.push_back(dat_w);
                sent++;
            end
            tick();
            budget++;
        end
        ack_w = 1'b0; stb_w = 1'b0;
        tick();
        check("rand_received", 32'(received), 32'(N_RAND));
        check("rand_model_empty", 32'(model_q.size()), 32'd0);
        check("rand_ovf", 32'(ovf_w), 32'd0);
        check("rand_level", 32'(level_w), 32'd0);
        check("rand_stb_idle", 32'(stb_o_w), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
